// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write path: widths, register count
// and the fixed requester indices used by the writeback/load/debug sources.
package regfile_pkg;
   localparam int unsigned ADDR_WIDTH = 5;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
   localparam int unsigned NUM_REQ    = 3;

   localparam int unsigned REQ_ALU    = 0;
   localparam int unsigned REQ_LOAD   = 1;
   localparam int unsigned REQ_DEBUG  = 2;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the scan starts one past the pointer
// and grants the first active request; a zero enable forces no grant.
module rr_arbiter #(
   parameter int unsigned N  = 3,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
)(
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   input  logic          i_enable,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_winner
);
   int unsigned w_idx;
   logic        w_found;

   always_comb begin
      o_grant  = '0;
      o_winner = '0;
      w_found  = 1'b0;
      w_idx    = 0;
      if (i_enable) begin
         for (int unsigned k = 1; k <= N; k++) begin
            w_idx = (32'(i_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
               w_found          = 1'b1;
               o_grant[w_idx]   = 1'b1;
               o_winner         = PW'(w_idx);
            end
         end
      end
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NUM_REQ requesters with a
// round-robin grant and one registered stage in front of the write port.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_REQ    = regfile_pkg::NUM_REQ,
   parameter int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH
)(
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          hold,
   output logic                          write_enable,
   output logic [ADDR_WIDTH-1:0]         write_address,
   output logic [DATA_WIDTH-1:0]         write_data_in,
   output logic [2**ADDR_WIDTH-1:0]      pending
);
   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]     w_grant;
   logic [PW-1:0]          w_winner;
   logic                   w_transfer;
   logic                   w_enable;
   logic [2**ADDR_WIDTH-1:0] w_pending;

   logic [PW-1:0]          r_last_grant;
   logic                   r_we;
   logic [ADDR_WIDTH-1:0]  r_waddr;
   logic [DATA_WIDTH-1:0]  r_wdata;

   // Reset is folded into the enable so no grant is offered while held in reset.
   assign w_enable = reset & ~hold;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_arb (
      .i_req    (req_valid),
      .i_ptr    (r_last_grant),
      .i_enable (w_enable),
      .o_grant  (w_grant),
      .o_winner (w_winner)
   );

   assign w_transfer = |w_grant;
   assign req_ready  = w_grant;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_last_grant <= PW'(NUM_REQ - 1);
         r_we         <= 1'b0;
         r_waddr      <= '0;
         r_wdata      <= '0;
      end else begin
         r_we <= w_transfer;
         if (w_transfer) begin
            r_last_grant <= w_winner;
            r_waddr      <= req_address[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata      <= req_data[w_winner*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_pending = '0;
      if (r_we) w_pending[r_waddr] = 1'b1;
   end

   assign write_enable  = r_we;
   assign write_address = r_waddr;
   assign write_data_in = r_wdata;
   assign pending       = w_pending;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a vector table for the steady
// stream plus hand sequences for collision and mid-operation reset.
module tb_regfile_write_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic        hold;
   logic [2:0]  req_valid;
   logic [14:0] req_address;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        write_enable;
   logic [4:0]  write_address;
   logic [31:0] write_data_in;
   logic [31:0] pending;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rf [32];

   always #5 clock = ~clock;

   regfile_write_arbiter #(
      .NUM_REQ    (3),
      .ADDR_WIDTH (5),
      .DATA_WIDTH (32)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_address   (req_address),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .hold          (hold),
      .write_enable  (write_enable),
      .write_address (write_address),
      .write_data_in (write_data_in),
      .pending       (pending)
   );

   // Register file stand-in: commits one edge after write_enable, drops writes under reset.
   always @(posedge clock) begin
      if (reset && write_enable) rf[write_address] <= write_data_in;
   end

   typedef struct {
      logic        rst_n;
      logic        hold;
      logic [2:0]  valid;
      logic [14:0] addr;
      logic [95:0] data;
      logic [2:0]  exp_ready;
      logic        chk_out;
      logic        exp_we;
      logic [4:0]  exp_wa;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs[$];

   localparam logic [14:0] A_RR = {5'd3, 5'd2, 5'd1};
   localparam logic [95:0] D_RR = {32'h300, 32'h200, 32'h100};
   localparam logic [14:0] A_SW = {5'd0, 5'd7, 5'd0};
   localparam logic [95:0] D_SW = {32'h0, 32'hDEAD_BEEF, 32'h0};

   task automatic add_vec(input logic rst_n, input logic hd, input logic [2:0] v,
                          input logic [14:0] a, input logic [95:0] d,
                          input logic [2:0] er, input logic chk, input logic ewe,
                          input logic [4:0] ewa, input logic [31:0] ewd);
      vec_t t;
      t.rst_n = rst_n; t.hold = hd; t.valid = v; t.addr = a; t.data = d;
      t.exp_ready = er; t.chk_out = chk; t.exp_we = ewe; t.exp_wa = ewa; t.exp_wd = ewd;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst_n, input logic hd, input logic [2:0] v,
                        input logic [14:0] a, input logic [95:0] d);
      reset = rst_n; hold = hd; req_valid = v; req_address = a; req_data = d;
   endtask

   // Inputs change just after the posedge; outputs are checked at the negedge.
   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic check_port(input string tag, input logic ewe, input logic [4:0] ewa,
                             input logic [31:0] ewd);
      check({tag, ".we"}, 32'(write_enable), 32'(ewe));
      check({tag, ".addr"}, 32'(write_address), 32'(ewa));
      check({tag, ".data"}, write_data_in, ewd);
      check({tag, ".pending"}, pending, ewe ? (32'd1 << ewa) : 32'd0);
   endtask

   initial begin
      drive(1'b0, 1'b0, 3'b000, '0, '0);

      //        rst hold valid addr  data  ready  chk we wa  wd
      add_vec(0, 0, 3'b111, A_RR, D_RR, 3'b000, 0, 0, 0, 32'h0);
      add_vec(0, 0, 3'b111, A_RR, D_RR, 3'b000, 1, 0, 0, 32'h0);
      add_vec(1, 0, 3'b111, A_RR, D_RR, 3'b001, 1, 0, 0, 32'h0);
      add_vec(1, 0, 3'b111, A_RR, D_RR, 3'b010, 1, 1, 1, 32'h100);
      add_vec(1, 0, 3'b111, A_RR, D_RR, 3'b100, 1, 1, 2, 32'h200);
      add_vec(1, 0, 3'b111, A_RR, D_RR, 3'b001, 1, 1, 3, 32'h300);
      add_vec(1, 0, 3'b111, A_RR, D_RR, 3'b010, 1, 1, 1, 32'h100);
      add_vec(1, 0, 3'b111, A_RR, D_RR, 3'b100, 1, 1, 2, 32'h200);
      add_vec(1, 1, 3'b111, A_RR, D_RR, 3'b000, 1, 1, 3, 32'h300);
      add_vec(1, 1, 3'b111, A_RR, D_RR, 3'b000, 1, 0, 3, 32'h300);
      add_vec(1, 1, 3'b111, A_RR, D_RR, 3'b000, 1, 0, 3, 32'h300);
      add_vec(1, 0, 3'b111, A_RR, D_RR, 3'b001, 1, 0, 3, 32'h300);
      add_vec(1, 0, 3'b111, A_RR, D_RR, 3'b010, 1, 1, 1, 32'h100);
      add_vec(1, 0, 3'b000, A_RR, D_RR, 3'b000, 1, 1, 2, 32'h200);
      add_vec(1, 0, 3'b000, A_RR, D_RR, 3'b000, 1, 0, 2, 32'h200);
      add_vec(1, 0, 3'b010, A_SW, D_SW, 3'b010, 1, 0, 2, 32'h200);
      add_vec(1, 0, 3'b000, A_SW, D_SW, 3'b000, 1, 1, 7, 32'hDEAD_BEEF);
      add_vec(1, 0, 3'b000, A_SW, D_SW, 3'b000, 1, 0, 7, 32'hDEAD_BEEF);

      foreach (vecs[i]) begin
         next_cycle();
         drive(vecs[i].rst_n, vecs[i].hold, vecs[i].valid, vecs[i].addr, vecs[i].data);
         @(negedge clock);
         check($sformatf("v%0d.ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
         if (vecs[i].chk_out)
            check_port($sformatf("v%0d", i), vecs[i].exp_we, vecs[i].exp_wa, vecs[i].exp_wd);
      end
      check("single.rf7", rf[7], 32'hDEAD_BEEF);

      // Collision: after a reset the pointer is at 2, so req 0 wins first, then req 2.
      next_cycle();
      drive(1'b0, 1'b0, 3'b000, '0, '0);
      next_cycle();
      drive(1'b1, 1'b0, 3'b101, {5'd3, 5'd0, 5'd3}, {32'd2, 32'd0, 32'd1});
      @(negedge clock);
      check("coll.ready0", 32'(req_ready), 32'(3'b001));
      check_port("coll.c0", 1'b0, 5'd0, 32'h0);
      next_cycle();
      req_valid = 3'b100;
      @(negedge clock);
      check("coll.ready2", 32'(req_ready), 32'(3'b100));
      check_port("coll.c1", 1'b1, 5'd3, 32'd1);
      next_cycle();
      req_valid = 3'b000;
      @(negedge clock);
      check_port("coll.c2", 1'b1, 5'd3, 32'd2);
      next_cycle();
      @(negedge clock);
      check("coll.we_off", 32'(write_enable), 32'd0);
      check("coll.rf3", rf[3], 32'd2);

      // Reset on the edge after a transfer: the write is dropped and the pointer rewinds.
      next_cycle();
      drive(1'b1, 1'b0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h55, 32'h0});
      @(negedge clock);
      check("rst.ready1", 32'(req_ready), 32'(3'b010));
      next_cycle();
      drive(1'b0, 1'b0, 3'b000, '0, '0);
      next_cycle();
      drive(1'b1, 1'b0, 3'b111, A_RR, D_RR);
      @(negedge clock);
      check_port("rst.after", 1'b0, 5'd0, 32'h0);
      check("rst.rf7", rf[7], 32'hDEAD_BEEF);
      check("rst.ready_first", 32'(req_ready), 32'(3'b001));
      next_cycle();
      req_valid = 3'b000;
      @(negedge clock);
      check_port("rst.regrant", 1'b1, 5'd1, 32'h100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
